fc_layer_sequencer: RTL and testbench

//  Schedules one fully-connected layer pass (default 400 in -> 120 out) on the 16-lane MAC/adder-tree datapath.

---
 rtl/fc_layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer pass: issues weight-ROM beats neuron-major,
// tracks them through the MAC/adder-tree latency and accumulates saturated neuron sums.
module fc_layer_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int INPUT_MAP  = 400,
    parameter int OUTPUT_MAP = 120,
    parameter int READ_SET   = 16,
    parameter int WEIGHT_LAT = 1,
    parameter int DP_LAT     = 5,
    parameter int PSUM_W     = 21,
    parameter int ACC_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  weight_rd_en,
    output logic [11:0]           weight_addr,
    output logic [4:0]            in_chunk_sel,
    input  logic [PSUM_W-1:0]     psum_in,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic [6:0]            result_index
);
    localparam int CHUNKS = INPUT_MAP / READ_SET;
    localparam int STAGES = WEIGHT_LAT + DP_LAT;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [6:0] neuron;
        logic [4:0] chunk;
    } beat_t;

    state_t                   state;
    logic [STAGES:0]          vld_pipe;
    beat_t                    beat_pipe [STAGES:0];
    logic [4:0]               chunk_cnt;
    logic [6:0]               neuron_cnt;
    logic [11:0]              addr_cnt;
    logic                     final_issued;
    logic signed [ACC_W-1:0]  acc;

    logic                     issue;
    logic                     is_final;
    logic                     chunk_wrap;
    logic signed [ACC_W-1:0]  psum_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DATA_WIDTH-1:0]    sat_data;

    always_comb begin
        chunk_wrap = (chunk_cnt == 5'(CHUNKS-1));
        is_final   = chunk_wrap && (neuron_cnt == 7'(OUTPUT_MAP-1));
        issue      = ((state == IDLE) && start) || ((state == ISSUE) && !final_issued);
        psum_ext   = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
        acc_sum    = (beat_pipe[STAGES].first ? '0 : acc) + psum_ext;
        if (acc_sum > SAT_MAX)
            sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (acc_sum < SAT_MIN)
            sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat_data = acc_sum[DATA_WIDTH-1:0];
    end

    // Pipe entries are zeroed when no beat is issued, so the chunk tap reads 0 for bubbles.
    assign in_chunk_sel = beat_pipe[WEIGHT_LAT].chunk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            weight_rd_en <= 1'b0;
            weight_addr  <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_index <= '0;
            vld_pipe     <= '0;
            chunk_cnt    <= '0;
            neuron_cnt   <= '0;
            addr_cnt     <= '0;
            final_issued <= 1'b0;
            acc          <= '0;
            for (int i = 0; i <= STAGES; i++) beat_pipe[i] <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            for (int i = 1; i <= STAGES; i++) beat_pipe[i] <= beat_pipe[i-1];

            if (issue) begin
                weight_rd_en <= 1'b1;
                weight_addr  <= addr_cnt;
                addr_cnt     <= addr_cnt + 12'd1;
                final_issued <= is_final;
                beat_pipe[0] <= '{first: (chunk_cnt == 5'd0), last: chunk_wrap,
                                  neuron: neuron_cnt, chunk: chunk_cnt};
                if (chunk_wrap) begin
                    chunk_cnt  <= '0;
                    neuron_cnt <= neuron_cnt + 7'd1;
                end else begin
                    chunk_cnt  <= chunk_cnt + 5'd1;
                end
            end else begin
                weight_rd_en <= 1'b0;
                weight_addr  <= '0;
                beat_pipe[0] <= '0;
            end

            result_valid <= 1'b0;
            if (vld_pipe[STAGES]) begin
                acc <= acc_sum;
                if (beat_pipe[STAGES].last) begin
                    result_valid <= 1'b1;
                    result_index <= beat_pipe[STAGES].neuron;
                    result_data  <= sat_data;
                end
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (final_issued) begin
                        state        <= DRAIN;
                        chunk_cnt    <= '0;
                        neuron_cnt   <= '0;
                        addr_cnt     <= '0;
                        final_issued <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Final neuron's result is on the outputs and nothing is left in flight.
                    if (vld_pipe == '0 && result_valid && result_index == 7'(OUTPUT_MAP-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: launches passes with known psum patterns, a monitor compares
// every result/done pulse and the issue stream against bench-computed expectations.
module tb_fc_layer_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [20:0] psum_in;
    logic busy, done, weight_rd_en, result_valid;
    logic [11:0] weight_addr;
    logic [4:0] in_chunk_sel;
    logic [15:0] result_data;
    logic [6:0] result_index;

    logic s_start = 1'b0;
    logic signed [20:0] s_psum;
    logic s_busy, s_done, s_rd_en, s_result_valid;
    logic [11:0] s_addr;
    logic [4:0] s_chunk;
    logic [15:0] s_data;
    logic [6:0] s_index;

    fc_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .in_chunk_sel(in_chunk_sel),
        .psum_in(psum_in), .result_valid(result_valid), .result_data(result_data),
        .result_index(result_index)
    );

    fc_layer_sequencer #(.INPUT_MAP(32), .OUTPUT_MAP(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .weight_rd_en(s_rd_en), .weight_addr(s_addr), .in_chunk_sel(s_chunk),
        .psum_in(s_psum), .result_valid(s_result_valid), .result_data(s_data),
        .result_index(s_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {int cyc; int idx; logic [15:0] data;} exp_t;
    exp_t exp_q[$];
    int   done_q[$];

    int pc = 0;
    int mode = 0;
    logic pass_on = 1'b0;
    int abort_cyc = 1 << 30;
    int pk;

    // Beat k of the current pass is sampled at the edge ending cycle pc+7+k.
    always_comb begin
        pk = cyc - pc - 7;
        psum_in = 21'sd1234;
        if (pass_on && pk >= 0 && pk < 3000) begin
            case (mode)
                0: psum_in = 21'sd1;
                1: psum_in = 21'sd524288;
                2: psum_in = -21'sd524288;
                default: psum_in = 21'(pk % 25) - 21'sd12;
            endcase
        end
    end

    int s_pc = 0;
    logic s_on = 1'b0;
    int s_k;
    always_comb begin
        s_k = cyc - s_pc - 7;
        s_psum = 21'sd777;
        if (s_on && s_k >= 0 && s_k < 4) s_psum = 21'(s_k + 1);
    end

    function automatic logic [15:0] expdata(input int m);
        case (m)
            0: return 16'd25;
            1: return 16'h7FFF;
            2: return 16'h8000;
            default: return 16'h0000;
        endcase
    endfunction

    // Result and done scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            e = exp_q.pop_front();
            chk("result_missing", 32'(cyc), 32'(e.cyc));
        end
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                chk("result_unexpected", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_cycle", 32'(cyc), 32'(e.cyc));
                chk("result_index", 32'(result_index), 32'(e.idx));
                chk("result_data", 32'(result_data), 32'(e.data));
            end
        end
        if (done_q.size() > 0 && cyc > done_q[0]) begin
            chk("done_missing", 32'(cyc), 32'(done_q.pop_front()));
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
            else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
    end

    // Issue stream: addresses contiguous over cycles pc+1..pc+3000, chunk select one cycle later.
    always @(negedge clk) begin
        int d;
        logic exp_rd, exp_ch_vld;
        d = cyc - pc;
        exp_rd = pass_on && d >= 1 && d <= 3000 && cyc < abort_cyc;
        exp_ch_vld = pass_on && d >= 2 && d <= 3001 && cyc < abort_cyc;
        chk("weight_rd_en", 32'(weight_rd_en), 32'(exp_rd));
        chk("weight_addr", 32'(weight_addr), exp_rd ? 32'(d - 1) : 32'd0);
        chk("in_chunk_sel", 32'(in_chunk_sel), exp_ch_vld ? 32'((d - 2) % 25) : 32'd0);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input int m);
        mode = m;
        pc = cyc;
        pass_on = 1'b1;
        abort_cyc = 1 << 30;
        for (int n = 0; n < 120; n++) exp_q.push_back('{pc + 25*n + 32, n, expdata(m)});
        done_q.push_back(pc + 3008);
        pulse_start();
    endtask

    initial begin
        int x, naddr, nres, ndone, last_res;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result_data", 32'(result_data), 0);
        chk("rst_result_index", 32'(result_index), 0);
        chk("rst_small_busy", 32'(s_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Small configuration: 2 chunks x 2 neurons, psum = beat+1.
        s_pc = cyc; s_on = 1'b1; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        naddr = 0; nres = 0; ndone = 0; last_res = -100;
        repeat (30) begin
            if (s_rd_en) begin
                chk("small_addr", 32'(s_addr), 32'(naddr));
                naddr++;
            end
            if (s_result_valid) begin
                chk("small_index", 32'(s_index), 32'(nres));
                chk("small_data", 32'(s_data), nres == 0 ? 32'd3 : 32'd7);
                chk("small_result_cycle", 32'(cyc - s_pc), nres == 0 ? 32'd9 : 32'd11);
                last_res = cyc;
                nres++;
            end
            if (s_done) begin
                chk("small_done_after_last", 32'(cyc), 32'(last_res + 1));
                ndone++;
            end
            @(negedge clk);
        end
        chk("small_addr_count", 32'(naddr), 4);
        chk("small_result_count", 32'(nres), 2);
        chk("small_done_count", 32'(ndone), 1);
        s_on = 1'b0;

        // Pass A (psum=1) with ignored starts at 500 and 3008, re-start at 3009.
        wait_until(60);
        x = cyc;
        chk("idle_busy", 32'(busy), 0);
        launch(0);
        chk("busy_first", 32'(busy), 1);
        wait_until(x + 500);
        pulse_start();
        wait_until(x + 3008);
        chk("busy_at_done", 32'(busy), 1);
        pulse_start();
        chk("busy_after_done", 32'(busy), 0);
        launch(1);
        wait_until(pc + 3020);
        launch(2);
        wait_until(pc + 3020);

        // Reset mid-pass: everything cleared, no further results.
        launch(0);
        wait_until(pc + 1500);
        rst_n = 1'b0;
        abort_cyc = cyc + 1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result_valid", 32'(result_valid), 0);
        chk("abort_result_data", 32'(result_data), 0);
        chk("abort_result_index", 32'(result_index), 0);
        wait_until(cyc + 200);

        launch(3);
        wait_until(pc + 3020);
        chk("results_pending", 32'(exp_q.size()), 0);
        chk("done_pending", 32'(done_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
